light_sequencer: RTL and testbench

- Parametrised successor to the 3-bit lights selector.
- Steps a 3-bit primary-colour code through the six non-black, non-white values. It supports manual (button-edge) and automatic (timed) stepping, up or down direction, and a freeze input.
- Drives a registered RGB word of configurable channel width, scaled by a brightness input, with a white override.
- Sits between the board button/switch logic and the LED driver.

---
 rtl/light_sequencer.sv | 91 +++++++++
 tb/tb_light_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// Colour stepper for the board LEDs: walks the six primary/secondary colour codes
// manually or on a timer, and drives a brightness-scaled, registered RGB word.
module light_sequencer #(
  parameter int CH_W     = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic                  auto,
  input  logic                  dir,
  input  logic                  hold,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [CH_W-1:0]       bright,
  input  logic                  sel,
  output logic [2:0]            colour,
  output logic                  step,
  output logic [3*CH_W-1:0]     light
);

  logic [2:0]          colour_q, colour_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                btn_q;
  logic                auto_q;
  logic                step_q, step_d;
  logic [3*CH_W-1:0]   light_q, light_d;

  logic [PERIOD_W-1:0] last_cnt;
  logic                auto_chg;
  logic                btn_edge;
  logic                expire;
  logic                adv;
  logic [2:0]          nxt_colour;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_q <= 3'd0;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      auto_q   <= 1'b0;
      step_q   <= 1'b0;
      light_q  <= '0;
    end else begin
      colour_q <= colour_d;
      cnt_q    <= cnt_d;
      btn_q    <= button;
      auto_q   <= auto;
      step_q   <= step_d;
      light_q  <= light_d;
    end
  end

  // Next-state logic: colour and period counter
  always_comb begin
    last_cnt   = (period == '0) ? '0 : period - PERIOD_W'(1);
    auto_chg   = auto ^ auto_q;
    btn_edge   = button & ~btn_q;
    expire     = (cnt_q >= last_cnt);
    adv        = auto ? (~auto_chg & expire) : btn_edge;
    nxt_colour = 3'd1;
    if (dir) begin
      nxt_colour = (colour_q == 3'd1) ? 3'd6 : colour_q - 3'd1;
    end else begin
      nxt_colour = (colour_q == 3'd6) ? 3'd1 : colour_q + 3'd1;
    end

    colour_d = colour_q;
    cnt_d    = cnt_q;
    if (!hold) begin
      cnt_d = (auto & ~auto_chg & ~expire) ? cnt_q + PERIOD_W'(1) : '0;
      if (adv) colour_d = nxt_colour;
    end
    // Leaving reset (code 0) or recovering from an illegal 7 always lands on 1, even under hold
    if (colour_q == 3'd0 || colour_q == 3'd7) colour_d = 3'd1;
  end

  // Output logic: step flag and per-channel brightness
  always_comb begin
    step_d = (colour_d != colour_q);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign light_d[gi*CH_W +: CH_W] = (!sel || colour_q[gi]) ? bright : '0;
  end

  assign colour = colour_q;
  assign step   = step_q;
  assign light  = light_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Randomised + directed bench for light_sequencer with a cycle-level reference model
// and a queue-based scoreboard checked by an independent monitor.
module tb_light_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        button, auto, dir, hold, sel;
  logic [15:0] period;
  logic [7:0]  bright;
  logic [2:0]  colour;
  logic        step;
  logic [23:0] light;

  light_sequencer #(.CH_W(8), .PERIOD_W(16)) dut (
    .clk(clk), .rst(rst), .button(button), .auto(auto), .dir(dir), .hold(hold),
    .period(period), .bright(bright), .sel(sel),
    .colour(colour), .step(step), .light(light)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  col;
    logic [23:0] lt;
  } exp_t;

  exp_t       cq[$];
  logic [2:0] sq[$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Reference model state
  int          m_col, m_cnt, m_btn, m_auto;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_cnt = 0; m_btn = 0; m_auto = 0;
  endtask

  // Predict the effect of the coming rising edge from the inputs now on the pins
  task automatic model_edge();
    exp_t e;
    int   lim, new_col;
    bit   adv, bedge;
    logic [23:0] lt;
    lim   = (period == 0) ? 1 : int'(period);
    bedge = button && (m_btn == 0);
    lt    = '0;
    for (int k = 0; k < 3; k++)
      if (!sel || ((m_col >> k) & 1)) lt[k*8 +: 8] = bright;
    adv = 0;
    if (!hold) begin
      if (int'(auto) != m_auto) begin
        m_cnt = 0;
        if (!auto && bedge) adv = 1;
      end else if (auto) begin
        if (m_cnt + 1 >= lim) begin adv = 1; m_cnt = 0; end
        else m_cnt++;
      end else begin
        m_cnt = 0;
        if (bedge) adv = 1;
      end
    end
    new_col = m_col;
    if (adv) new_col = dir ? ((m_col + 4) % 6) + 1 : (m_col % 6) + 1;
    if (m_col < 1 || m_col > 6) new_col = 1;
    e.st  = (new_col != m_col);
    e.col = 3'(new_col);
    e.lt  = lt;
    cq.push_back(e);
    if (e.st) sq.push_back(3'(new_col));
    m_col  = new_col;
    m_btn  = int'(button);
    m_auto = int'(auto);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    button = 1'b1; tick();
    button = 1'b0; tick();
  endtask

  task automatic goto_colour(input int c);
    for (int i = 0; i < 12 && m_col != c; i++) pulse();
    check("goto_colour", 32'(colour), 32'(c));
  endtask

  // Monitor: compare DUT outputs just after each rising edge
  always @(posedge clk) begin
    exp_t e;
    logic [2:0] c;
    #1;
    if (mon_en) begin
      if (cq.size() == 0) begin
        check("cycle_queue_underflow", 32'(cq.size()), 32'd1);
      end else begin
        e = cq.pop_front();
        check("colour", 32'(colour), 32'(e.col));
        check("step",   32'(step),   32'(e.st));
        check("light",  32'(light),  32'(e.lt));
      end
      if (step) begin
        if (sq.size() == 0) check("unexpected_step", 32'(step), 32'd0);
        else begin
          c = sq.pop_front();
          check("step_colour", 32'(colour), 32'(c));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; button = 1'b0; auto = 1'b0; dir = 1'b0; hold = 1'b1;
    period = 16'd4; bright = 8'hFF; sel = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("reset_colour", 32'(colour), 32'd0);
      check("reset_light",  32'(light),  32'd0);
      check("reset_step",   32'(step),   32'd0);
    end

    // Start-up under hold
    rst = 1'b0; mon_en = 1'b1;
    tick();
    check("startup_colour", 32'(colour), 32'd1);
    check("startup_step",   32'(step),   32'd1);
    tick();
    check("startup_light",  32'(light),  32'h0000FF);
    hold = 1'b0;

    // Manual stepping and wrap
    for (int i = 0; i < 6; i++) pulse();
    check("manual_wrap", 32'(colour), 32'd1);

    // Direction
    dir = 1'b1; pulse();
    check("down_wrap", 32'(colour), 32'd6);
    check("down_light", 32'(light), 32'hFFFF00);
    dir = 1'b0; pulse();
    check("up_wrap", 32'(colour), 32'd1);

    // Held button: one step only
    button = 1'b1; run(10); button = 1'b0; tick();
    check("held_button", 32'(colour), 32'd2);

    // Auto timing, ignored button, period 0
    auto = 1'b1; period = 16'd4; run(20);
    for (int i = 0; i < 10; i++) begin button = ~button; tick(); end
    button = 1'b0;
    period = 16'd0; run(8);
    period = 16'd1; run(4);

    // Hold in auto mode
    period = 16'd3; hold = 1'b1; run(20); hold = 1'b0; run(6);

    // White and brightness
    sel = 1'b0; bright = 8'h40; tick(); tick();
    check("white_light", 32'(light), 32'h404040);
    auto = 1'b0; sel = 1'b1; tick();
    goto_colour(5);
    tick();
    check("colour5_light", 32'(light), 32'h400040);
    bright = 8'h00; tick(); tick();
    check("dark_light", 32'(light), 32'h000000);
    bright = 8'hFF;

    // Async reset mid-run
    goto_colour(4);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_colour", 32'(colour), 32'd0);
    check("async_light",  32'(light),  32'd0);
    check("async_step",   32'(step),   32'd0);
    cq.delete(); sq.delete();
    @(negedge clk);
    rst = 1'b0; model_reset(); mon_en = 1'b1;
    tick();
    check("restart_colour", 32'(colour), 32'd1);

    // Randomised phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2, 0) == 0) button = ~button;
      if ($urandom_range(39, 0) == 0) auto = ~auto;
      if ($urandom_range(7, 0) == 0) dir = ~dir;
      if ($urandom_range(19, 0) == 0) hold = ~hold;
      if ($urandom_range(15, 0) == 0) period = 16'($urandom_range(6, 0));
      if ($urandom_range(9, 0) == 0) bright = 8'($urandom);
      if ($urandom_range(9, 0) == 0) sel = ~sel;
      tick();
    end

    mon_en = 1'b0;
    check("cycle_queue_drained", 32'(cq.size()), 32'd0);
    check("step_queue_drained",  32'(sq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
